// File: rtl/adder_pkg.sv
// Shared geometry for the pipelined ripple adder: default widths, chunk sizing, legality check.
// Combinational helpers only.
package adder_pkg;

  localparam int NUMBITS_DEFAULT   = 16;
  localparam int NUMSTAGES_DEFAULT = 4;

  function automatic int chunk_width(input int numbits, input int numstages);
    return numbits / numstages;
  endfunction

  // Short-circuit keeps the modulo away from a zero stage count.
  function automatic bit geometry_ok(input int numbits, input int numstages);
    return (numstages >= 1) && ((numbits % numstages) == 0);
  endfunction

  localparam bit DEFAULT_GEOMETRY_OK = geometry_ok(NUMBITS_DEFAULT, NUMSTAGES_DEFAULT);

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational ripple of full_adder cells with optional B inversion for subtract.
// Zero latency; RIPPLE_ADDER_OVERFLOW_EN adds the signed-overflow output for the top chunk.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
`ifdef RIPPLE_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  logic [CHUNK-1:0] bx;
  logic [CHUNK:0]   c;

  assign bx   = b ^ {CHUNK{sub}};
  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (bx[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[CHUNK];

`ifdef RIPPLE_ADDER_OVERFLOW_EN
  assign ovf = c[CHUNK] ^ c[CHUNK-1];
`endif

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell; combinational, zero latency.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_ripple_adder.sv
// NUMSTAGES-deep pipelined add/sub, one CHUNK ripple per stage; latency NUMSTAGES, one op per cycle.
// Whole pipe freezes while the output is stalled; RIPPLE_ADDER_OVERFLOW_EN adds the overflow port.
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int NUMBITS   = NUMBITS_DEFAULT,
  parameter int NUMSTAGES = NUMSTAGES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  input  logic               carryin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] result,
  output logic               carryout
`ifdef RIPPLE_ADDER_OVERFLOW_EN
  ,
  output logic               overflow
`endif
);

  localparam int CHUNK = chunk_width(NUMBITS, NUMSTAGES);

  if (!geometry_ok(NUMBITS, NUMSTAGES)) begin : g_geometry_err
    $error("pipelined_ripple_adder: NUMBITS must be a multiple of NUMSTAGES >= 1");
  end

  // Operands ride along the whole pipe; s accumulates finished low chunks, c is the inter-stage carry.
  typedef struct packed {
    logic [NUMBITS-1:0] a;
    logic [NUMBITS-1:0] b;
    logic [NUMBITS-1:0] s;
    logic               sub;
    logic               c;
  } stage_t;

  stage_t                         cur   [NUMSTAGES];
  stage_t                         nxt   [NUMSTAGES];
  stage_t                         stg_q [NUMSTAGES];
  logic [NUMSTAGES-1:0]           cur_vld;
  logic [NUMSTAGES-1:0]           vld_q;
  logic [NUMSTAGES-1:0][CHUNK-1:0] sum_ck;
  logic [NUMSTAGES-1:0]           cout_ck;
  logic                           started_q;
  logic                           stall;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
  logic [NUMSTAGES-1:0]           ovf_ck;
  logic                           ovf_q;
`endif

  assign stall    = out_valid && !out_ready;
  assign in_ready = started_q && !stall;

  for (genvar k = 0; k < NUMSTAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign cur[k]     = '{a: A, b: B, s: '0, sub: sub, c: carryin};
      assign cur_vld[k] = in_valid && in_ready;
    end else begin : g_tail
      assign cur[k]     = stg_q[k-1];
      assign cur_vld[k] = vld_q[k-1];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (cur[k].a[k*CHUNK +: CHUNK]),
      .b    (cur[k].b[k*CHUNK +: CHUNK]),
      .sub  (cur[k].sub),
      .cin  (cur[k].c),
      .s    (sum_ck[k]),
      .cout (cout_ck[k])
`ifdef RIPPLE_ADDER_OVERFLOW_EN
      ,
      .ovf  (ovf_ck[k])
`endif
    );

    // Bits at and above chunk k are still zero in s, so OR-ing drops the new chunk into place.
    assign nxt[k] = '{a:   cur[k].a,
                      b:   cur[k].b,
                      s:   cur[k].s | (NUMBITS'(sum_ck[k]) << (k*CHUNK)),
                      sub: cur[k].sub,
                      c:   cout_ck[k]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      vld_q     <= '0;
      for (int k = 0; k < NUMSTAGES; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      started_q <= 1'b1;
      if (!stall) begin
        vld_q <= cur_vld;
        for (int k = 0; k < NUMSTAGES; k++) begin
          stg_q[k] <= nxt[k];
        end
      end
    end
  end

  assign out_valid = vld_q[NUMSTAGES-1];
  assign result    = stg_q[NUMSTAGES-1].s;
  assign carryout  = stg_q[NUMSTAGES-1].c;

`ifdef RIPPLE_ADDER_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (!stall) begin
      ovf_q <= ovf_ck[NUMSTAGES-1];
    end
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed bench for pipelined_ripple_adder (16 bits, 4 stages): vector table plus
// back-to-back, stall and mid-flight reset sequences; overflow checks when RIPPLE_ADDER_OVERFLOW_EN is set.
module tb_pipelined_ripple_adder;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] res;
    logic        co;
    logic        ov;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        carryin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carryout;
`ifdef RIPPLE_ADDER_OVERFLOW_EN
  logic        overflow;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] mon_res [$];
  logic        mon_co  [$];
  int          mon_cyc [$];
  int          cyc_cnt = 0;

  vec_t tbl [12];

  pipelined_ripple_adder #(.NUMBITS(16), .NUMSTAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .carryin   (carryin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carryout  (carryout)
`ifdef RIPPLE_ADDER_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1, so the negedge sees exactly what the next posedge will transfer.
  always @(negedge clk) begin
    cyc_cnt++;
    if (rst_n && out_valid && out_ready) begin
      mon_res.push_back(result);
      mon_co.push_back(carryout);
      mon_cyc.push_back(cyc_cnt);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mon_clear();
    mon_res.delete();
    mon_co.delete();
    mon_cyc.delete();
  endtask

  // Single isolated transaction: checks latency, result, carryout (and overflow when present).
  task automatic run_vec(input vec_t v, input string nm);
    int cnt;
    A         = v.a;
    B         = v.b;
    carryin   = v.cin;
    sub       = v.sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk($sformatf("%s_latency", nm), 32'(cnt), 32'd4);
    chk($sformatf("%s_result", nm), 32'(result), 32'(v.res));
    chk($sformatf("%s_carryout", nm), 32'(carryout), 32'(v.co));
`ifdef RIPPLE_ADDER_OVERFLOW_EN
    chk($sformatf("%s_overflow", nm), 32'(overflow), 32'(v.ov));
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] held;
    logic [15:0] exp16;
    int          issued;
    int          stall_left;
    logic        xfer;

    //             a         b         cin   sub   res       co    ov
    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[2]  = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[3]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[6]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[9]  = '{16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[10] = '{16'hABCD, 16'h1234, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b0};
    tbl[11] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    carryin   = 1'b0;
    sub       = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_carryout", 32'(carryout), 32'd0);
`ifdef RIPPLE_ADDER_OVERFLOW_EN
    chk("reset_overflow", 32'(overflow), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: A=i, B=0x1000*i, expect eight consecutive in-order results.
    mon_clear();
    out_ready = 1'b1;
    carryin   = 1'b0;
    sub       = 1'b0;
    for (int i = 0; i < 8; i++) begin
      A        = 16'(i);
      B        = 16'(i * 16'h1000);
      in_valid = 1'b1;
      #1;
      chk($sformatf("b2b_in_ready%0d", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int w = 0; w < 20 && mon_res.size() < 8; w++) begin
      @(posedge clk); #1;
    end
    chk("b2b_count", 32'(mon_res.size()), 32'd8);
    for (int i = 0; i < 8 && i < mon_res.size(); i++) begin
      exp16 = 16'(i + i * 16'h1000);
      chk($sformatf("b2b_result%0d", i), 32'(mon_res[i]), 32'(exp16));
      chk($sformatf("b2b_carryout%0d", i), 32'(mon_co[i]), 32'd0);
      chk($sformatf("b2b_consecutive%0d", i), 32'(mon_cyc[i] - mon_cyc[0]), 32'(i));
    end

    // Stall: six ops (0xF000+i)+0x1001 -> result i+1, carryout 1; out_ready low 5 cycles at first result.
    mon_clear();
    issued     = 0;
    stall_left = -1;
    held       = '0;
    for (int cyc = 0; cyc < 60 && mon_res.size() < 6; cyc++) begin
      if (out_valid && stall_left < 0) begin
        stall_left = 5;
        held       = result;
      end
      out_ready = !(stall_left > 0);
      in_valid  = (issued < 6);
      A         = 16'(16'hF000 + issued);
      B         = 16'h1001;
      #1;
      if (stall_left > 0) begin
        chk($sformatf("stall_in_ready%0d", stall_left), 32'(in_ready), 32'd0);
        chk($sformatf("stall_out_valid%0d", stall_left), 32'(out_valid), 32'd1);
        chk($sformatf("stall_hold%0d", stall_left), 32'(result), 32'(held));
        stall_left--;
      end
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      if (xfer) issued++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stall_held_value", 32'(held), 32'h0001);
    chk("stall_count", 32'(mon_res.size()), 32'd6);
    for (int i = 0; i < 6 && i < mon_res.size(); i++) begin
      chk($sformatf("stall_result%0d", i), 32'(mon_res[i]), 32'(i + 1));
      chk($sformatf("stall_carryout%0d", i), 32'(mon_co[i]), 32'd1);
    end

    // Reset with three ops still in flight behind a visible result.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      A        = (i == 0) ? 16'hFFFF : 16'(16'h0100 * i);
      B        = (i == 0) ? 16'h0002 : 16'h0011;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("rst_pre_out_valid", 32'(out_valid), 32'd1);
    chk("rst_pre_result", 32'(result), 32'h0001);
    chk("rst_pre_carryout", 32'(carryout), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", 32'(out_valid), 32'd0);
    chk("rst_async_result", 32'(result), 32'd0);
    chk("rst_async_carryout", 32'(carryout), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    mon_clear();
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_stale", 32'(mon_res.size()), 32'd0);
    run_vec(tbl[3], "rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
Parametrised, pipelined successor to the team's single-cycle ripple-carry adder. It splits an NUMBITS-wide add/subtract into NUMSTAGES ripple chunks with a register between chunks. Operands enter and results leave over valid/ready handshakes with full backpressure. It sits between operand-issue logic and result writeback in the datapath.

Parameters:
NUMBITS, 16, operand and result width; must be a multiple of NUMSTAGES
NUMSTAGES, 4, number of pipeline stages; CHUNK = NUMBITS/NUMSTAGES bits ripple per stage; NUMSTAGES >= 1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands this cycle
A  input  NUMBITS  operand A
B  input  NUMBITS  operand B
carryin  input  1  carry into bit 0
sub  input  1  0: A+B+carryin; 1: A+~B+carryin
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  NUMBITS  sum/difference, modulo 2^NUMBITS
carryout  output  1  carry out of bit NUMBITS-1 (for sub: 1 = no borrow)

Behaviour:
- Reset (rst_n low, async): all stage valid bits 0, all data/carry registers 0; out_valid=0, result=0, carryout=0. in_ready=1 one cycle after reset deasserts. Reset mid-operation discards all in-flight transactions, with no partial output.
- Transfer rules: input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
- stall = out_valid && !out_ready. in_ready = !stall. While stalled, every stage register holds.
- Stage k (0..NUMSTAGES-1): ripples chunk k with CHUNK full-adder cells. Carry input is carryin for k=0, else the carry registered by stage k-1. Lower result chunks already computed are passed forward; upper operand chunks are delayed alongside.
- B chunk is inverted when the transaction's sub bit is set. sub travels with the transaction.
- Latency: exactly NUMSTAGES cycles from input transfer to out_valid with no stall. Throughput: one transaction per cycle.
- Valid bubbles propagate. An empty stage never blocks the stages behind it only while the output is not stalled; no bubble-collapsing is required.
- Ordering: results leave strictly in issue order. There is no drop and no duplication under any in_ready/out_ready pattern.
- result and carryout hold stable while out_valid && !out_ready.
- Arithmetic wraps modulo 2^NUMBITS. carryout is the raw bit NUMBITS carry.
- NUMSTAGES=1: degenerates to one registered ripple adder, latency 1.

Optional Feature:
Macro RIPPLE_ADDER_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit). It is the two's-complement signed overflow, computed as carry into MSB XOR carry out of MSB. It is registered with result, resets to 0, and holds under stall like result.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package (adder_pkg): default NUMBITS/NUMSTAGES constants; a function computing CHUNK; a compile-time check constant/assertion for NUMBITS % NUMSTAGES == 0.
- Sub-module adder_chunk (CHUNK-bit combinational ripple of the existing full_adder cell, with sub inversion and carry in/out). It is generated once per stage.
- The top level holds the pipeline registers and handshake.

Test Plan:
- NUMBITS=16, NUMSTAGES=4; A=0xFFFF, B=0x0001, carryin=0, sub=0, out_ready=1 -> exactly 4 cycles later out_valid=1, result=0x0000, carryout=1.
- sub=1, carryin=1, A=0x0005, B=0x0007 -> result=0xFFFE, carryout=0. A=0x0007, B=0x0005 -> result=0x0002, carryout=1.
- 8 back-to-back operand pairs (A=i, B=0x1000*i) with out_ready=1 -> 8 consecutive out_valid cycles, correct in-order sums, in_ready never low.
- Issue 6 transactions; hold out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 during the stall, result held stable, all 6 results delivered in order after release.
- Pull rst_n low with 3 transactions in flight -> out_valid, result and carryout go to 0 immediately. After release, no stale results appear; the next input yields a correct result after 4 cycles.
- With RIPPLE_ADDER_OVERFLOW_EN defined: 0x7FFF+0x0001 -> result=0x8000, overflow=1. 0xFFFF+0x0001 -> overflow=0, carryout=1.
